fp_vq_search_ctrl: RTL and testbench

- Sequential nearest-codeword search controller for the Codec2 encoder quantisers (LSP/energy/pitch).
- Scans an external codebook ROM one entry at a time and shares one subtract/square/compare datapath across all entries.
- The datapath is built from qadd, qmult and fplessthan in Q16.16 sign-magnitude format.
- Reports the index and squared error of the closest entry to a target value.

---
 rtl/fp_vq_pkg.sv | 26 ++
 rtl/fp_sq_err.sv | 22 ++
 rtl/fplessthan.sv | 21 ++
 rtl/qadd.sv | 21 ++
 rtl/qmult.sv | 18 +
 rtl/fp_vq_search_ctrl.sv | 133 +++++++++++++
 tb/tb_fp_vq_search_ctrl.sv | 240 ++++++++++++++++++++++++
 7 files changed

// File: rtl/fp_vq_pkg.sv
// Shared constants and state encodings for the Q16.16 codebook search controller.
package fp_vq_pkg;
  localparam int N_DEF = 32;
  localparam int Q_DEF = 16;

  localparam logic [31:0] FP_MAXPOS = 32'h7FFFFFFF;
  localparam logic [31:0] FP_ONE    = 32'h00010000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_DIFF  = 3'd3;
  localparam logic [2:0] ST_SQR   = 3'd4;
  localparam logic [2:0] ST_CMP   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_LOAD  = ST_LOAD,
    S_DIFF  = ST_DIFF,
    S_SQR   = ST_SQR,
    S_CMP   = ST_CMP,
    S_DONE  = ST_DONE
  } state_t;
endpackage

// File: rtl/fp_sq_err.sv
// Squared error d*d with clamp to the largest positive value once |d| >= 256.0.
module fp_sq_err
  import fp_vq_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic [N-1:0] d,
  output logic [N-1:0] sq
);
  logic [N-1:0] prod;
  logic         sat;
  logic         unused_sign;

  qmult #(.N(N), .Q(Q)) u_mult (.a(d), .b(d), .r(prod));

  // Any integer magnitude bit at or above 2^8 means the square no longer fits.
  assign sat         = |d[N-2:Q+8];
  // The sign bit is forced clear so -0 can never reach the comparator.
  assign sq          = sat ? {1'b0, {(N-1){1'b1}}} : {1'b0, prod[N-2:0]};
  assign unused_sign = prod[N-1];
endmodule

// File: rtl/fplessthan.sv
// Sign-magnitude less-than comparator.
module fplessthan
  import fp_vq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);
  // Opposite signs: the negative one is smaller; negatives order by reversed magnitude.
  always_comb begin
    if (a[N-1] != b[N-1]) begin
      lt = a[N-1];
    end else if (a[N-1]) begin
      lt = a[N-2:0] > b[N-2:0];
    end else begin
      lt = a[N-2:0] < b[N-2:0];
    end
  end
endmodule

// File: rtl/qadd.sv
// Sign-magnitude fixed-point adder (magnitude wraps; no saturation).
module qadd
  import fp_vq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c
);
  // Same signs add magnitudes; opposite signs subtract the smaller from the larger.
  always_comb begin
    if (a[N-1] == b[N-1]) begin
      c = {a[N-1], a[N-2:0] + b[N-2:0]};
    end else if (a[N-2:0] > b[N-2:0]) begin
      c = {a[N-1], a[N-2:0] - b[N-2:0]};
    end else begin
      c = {b[N-1], b[N-2:0] - a[N-2:0]};
    end
  end
endmodule

// File: rtl/qmult.sv
// Sign-magnitude fixed-point multiplier; keeps magnitude bits [N-2+Q:Q] of the product.
module qmult
  import fp_vq_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] r
);
  logic [2*N-3:0] prod;
  logic           unused_prod;

  assign prod        = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
  assign r           = {a[N-1] ^ b[N-1], prod[N-2+Q:Q]};
  assign unused_prod = ^{prod[2*N-3:N-1+Q], prod[Q-1:0]};
endmodule

// File: rtl/fp_vq_search_ctrl.sv
// Nearest-codeword search: walks the codebook ROM, five cycles per entry, on one shared datapath.
module fp_vq_search_ctrl
  import fp_vq_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int Q       = Q_DEF,
  parameter int ENTRIES = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      target,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [N-1:0]      rom_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] best_index,
  output logic [N-1:0]      best_err
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   i_q, i_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   best_index_q, best_index_d;
  logic [N-1:0]        target_q, target_d;
  logic [N-1:0]        cand_q, cand_d;
  logic [N-1:0]        d_q, d_d;
  logic [N-1:0]        sq_q, sq_d;
  logic [N-1:0]        best_err_q, best_err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [N-1:0]        diff_w;
  logic [N-1:0]        sq_w;
  logic                lt_w;

  qadd       #(.N(N))        u_add (.a(target_q), .b({~cand_q[N-1], cand_q[N-2:0]}), .c(diff_w));
  fp_sq_err  #(.N(N), .Q(Q)) u_sq  (.d(d_q), .sq(sq_w));
  fplessthan #(.N(N))        u_lt  (.a(sq_q), .b(best_err_q), .lt(lt_w));

  assign rom_addr   = rom_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign best_index = best_index_q;
  assign best_err   = best_err_q;

  // State and datapath registers; reset aborts any search in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      i_q          <= '0;
      rom_addr_q   <= '0;
      best_index_q <= '0;
      target_q     <= '0;
      cand_q       <= '0;
      d_q          <= '0;
      sq_q         <= '0;
      best_err_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      rom_addr_q   <= rom_addr_d;
      best_index_q <= best_index_d;
      target_q     <= target_d;
      cand_q       <= cand_d;
      d_q          <= d_d;
      sq_q         <= sq_d;
      best_err_q   <= best_err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic: the address is loaded on entry to FETCH so it is stable there and held after.
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    rom_addr_d   = rom_addr_q;
    best_index_d = best_index_q;
    target_d     = target_q;
    cand_d       = cand_q;
    d_d          = d_q;
    sq_d         = sq_q;
    best_err_d   = best_err_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d   = target;
          i_d        = '0;
          rom_addr_d = '0;
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        cand_d  = rom_data;
        state_d = S_DIFF;
      end
      S_DIFF: begin
        d_d     = diff_w;
        state_d = S_SQR;
      end
      S_SQR: begin
        sq_d    = sq_w;
        state_d = S_CMP;
      end
      S_CMP: begin
        // Strict less-than keeps the lowest index on a tie.
        if (i_q == '0 || lt_w) begin
          best_err_d   = sq_q;
          best_index_d = i_q;
        end
        if (i_q == LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          i_d        = i_q + ADDR_W'(1);
          rom_addr_d = i_q + ADDR_W'(1);
          state_d    = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_fp_vq_search_ctrl.sv
// Scoreboard bench for fp_vq_search_ctrl: directed cases plus randomized codebooks.
module tb_fp_vq_search_ctrl;
  import fp_vq_pkg::*;

  localparam int E  = 4;
  localparam int AW = 2;
  localparam int LAT = 5 * E;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   target;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] best_index;
  logic [31:0]   best_err;

  logic [31:0]   rom [E];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  typedef struct {
    logic [AW-1:0] idx;
    logic [31:0]   err;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  logic [AW-1:0] last_idx;
  logic [31:0]   last_err;

  fp_vq_search_ctrl #(.N(32), .Q(16), .ENTRIES(E), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done),
    .best_index(best_index), .best_err(best_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint sm2int(input logic [31:0] v);
    return v[31] ? -longint'({33'd0, v[30:0]}) : longint'({33'd0, v[30:0]});
  endfunction

  // Reference: real-valued error per entry in Q16 units, squared, clamped, then arg-min.
  task automatic model(input logic [31:0] t, output logic [AW-1:0] bi, output logic [31:0] be);
    longint best = 0;
    bi = '0;
    for (int k = 0; k < E; k++) begin
      longint dl = sm2int(t) - sm2int(rom[k]);
      longint e;
      if (dl < 0) dl = -dl;
      if (dl >= (longint'(256) << 16)) e = 64'h7FFFFFFF;
      else e = ((dl * dl) >> 16) & 64'h7FFFFFFF;
      if (k == 0 || e < best) begin
        best = e;
        bi = AW'(k);
      end
    end
    be = best[31:0];
  endtask

  // Pulse start for one edge; when a result is expected, queue it with its due cycle.
  task automatic start_search(input logic [31:0] t, input bit expect_result);
    exp_t ex;
    target = t;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (expect_result) begin
      model(t, ex.idx, ex.err);
      ex.due = cyc + LAT;
      exp_q.push_back(ex);
      last_idx = ex.idx;
      last_err = ex.err;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < LAT + 20 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("done_timeout_pending", 64'(exp_q.size()), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
  endtask

  function automatic logic [31:0] rnd_val();
    logic [30:0] mag;
    case ($urandom_range(0, 3))
      0:       mag = 31'($urandom_range(0, 32'h0003FFFF));
      1:       mag = 31'($urandom_range(0, 32'h00FFFFFF));
      2:       mag = 31'($urandom_range(0, 32'h000FFFFF));
      default: mag = 31'($urandom & 32'h1FFFFFFF);
    endcase
    return {1'($urandom_range(0, 1)), mag};
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation, on time.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        exp_t ex;
        ex = exp_q.pop_front();
        check("best_index", best_index, ex.idx);
        check("best_err", best_err, ex.err);
        check("best_err_sign", best_err[31], 0);
        check("done_cycle", 64'(cyc), 64'(ex.due));
        check("busy_at_done", busy, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    target = '0;
    for (int k = 0; k < E; k++) rom[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_best_index", best_index, 0);
    check("rst_best_err", best_err, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic search with busy window and fetch addresses.
    rom[0] = 32'h00000000; rom[1] = 32'h00010000; rom[2] = 32'h00028000; rom[3] = 32'h00040000;
    start_search(32'h00030000, 1'b1);
    check("basic_model_idx", last_idx, 2);
    check("basic_model_err", last_err, 32'h00004000);
    for (int c = 1; c <= LAT + 1; c++) begin
      check("busy_window", busy, (c <= LAT) ? 1 : 0);
      if ((c - 1) % 5 == 0 && c <= LAT) check("fetch_addr", rom_addr, 64'((c - 1) / 5));
      @(posedge clk); #1;
    end
    wait_idle();
    check("hold_index", best_index, 2);
    check("hold_err", best_err, 32'h00004000);

    // Tie between entries 0 and 2.
    rom[0] = 32'h00020000; rom[1] = 32'h00050000; rom[2] = 32'h00040000; rom[3] = 32'h00070000;
    start_search(32'h00030000, 1'b1);
    @(posedge clk); #1;
    check("not_cleared_at_start", best_err, 32'h00004000);
    wait_idle();
    check("tie_index", best_index, 0);

    // Negative operands.
    rom[0] = 32'h000A0000; rom[1] = 32'h000A0000; rom[2] = 32'h000A0000; rom[3] = 32'h80014000;
    start_search(32'h80010000, 1'b1);
    wait_idle();
    check("neg_index", best_index, 3);
    check("neg_err", best_err, 32'h00001000);

    // Saturation: every error clamps, tie rule picks entry 0.
    rom[0] = 32'h012C0000; rom[1] = 32'h01000000; rom[2] = 32'h012C0000; rom[3] = 32'h012C0000;
    start_search(32'h00000000, 1'b1);
    wait_idle();
    check("sat_err", best_err, 32'h7FFFFFFF);
    check("sat_index", best_index, 0);

    // Protocol: starts at cycle 3 and at the done cycle are ignored.
    rom[0] = 32'h00000000; rom[1] = 32'h00010000; rom[2] = 32'h00028000; rom[3] = 32'h00040000;
    start_search(32'h00030000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    target = 32'h00000000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (LAT + 1 - 4) @(posedge clk);
    #1;
    check("proto_done_cycle21", done, 1);
    target = 32'h00000000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("proto_start_at_done_ignored", busy, 0);
    @(posedge clk); #1;
    check("proto_still_idle", busy, 0);
    check("proto_index", best_index, 2);
    check("proto_queue_empty", 64'(exp_q.size()), 0);

    // Reset at cycle 10 aborts with no done.
    start_search(32'h00030000, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rom_addr", rom_addr, 0);
    check("abort_best_index", best_index, 0);
    check("abort_best_err", best_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (LAT + 5) @(posedge clk);
    #1;
    check("abort_no_busy", busy, 0);
    start_search(32'h00030000, 1'b1);
    wait_idle();
    check("after_abort_index", best_index, 2);

    // Randomized codebooks, with forced duplicates to exercise ties.
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < E; k++) begin
        rom[k] = rnd_val();
        if (k > 0 && $urandom_range(0, 4) == 0) rom[k] = rom[0];
      end
      start_search(rnd_val(), 1'b1);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
